// File: rtl/lsu_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_mem_arbiter: round-robin share of one data-memory port among NUM_REQ   |
// | load/store requesters, one operation at a time, with read timeout.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lsu_mem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_REQ-1:0]    rq_valid_i,
  input  logic [NUM_REQ-1:0]    rq_we_i,
  input  logic [NUM_REQ*64-1:0] rq_addr_i,
  input  logic [NUM_REQ*64-1:0] rq_wdata_i,
  output logic [NUM_REQ-1:0]    rq_ready_o,
  output logic [NUM_REQ-1:0]    rsp_valid_o,
  output logic [63:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  output logic                  mem_ren_o,
  output logic [63:0]           mem_raddr_o,
  input  logic                  mem_rvalid_i,
  input  logic [63:0]           mem_rdata_i,
  output logic                  mem_wen_o,
  output logic [63:0]           mem_waddr_o,
  output logic [63:0]           mem_wdata_o
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2
  } state_e;

  state_e               state_q;
  logic [IDW-1:0]       rr_last_q;
  logic [IDW-1:0]       id_q;
  logic [CW-1:0]        cnt_q;
  logic                 mem_ren_q;
  logic                 mem_wen_q;
  logic [63:0]          raddr_q;
  logic [63:0]          waddr_q;
  logic [63:0]          wdata_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [63:0]          rsp_rdata_q;
  logic                 rsp_err_q;

  logic                 win_valid;
  logic [IDW-1:0]       win_id;
  logic                 sel_we;
  logic [63:0]          sel_addr;
  logic [63:0]          sel_wdata;

  function automatic logic [IDW-1:0] slot(input logic [IDW-1:0] last, input int k);
    int s;
    s = (int'(last) + k) % NUM_REQ;
    return IDW'(s);
  endfunction

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    win_valid  = 1'b0;
    win_id     = '0;
    rq_ready_o = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_valid && rq_valid_i[slot(rr_last_q, k)]) begin
        win_valid = 1'b1;
        win_id    = slot(rr_last_q, k);
      end
    end
    if (state_q == IDLE && win_valid) rq_ready_o[win_id] = 1'b1;
    sel_we    = rq_we_i[win_id];
    sel_addr  = rq_addr_i[64*int'(win_id) +: 64];
    sel_wdata = rq_wdata_i[64*int'(win_id) +: 64];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rr_last_q   <= ID_LAST;
      id_q        <= '0;
      cnt_q       <= '0;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (win_valid) begin
            id_q      <= win_id;
            rr_last_q <= win_id;
            cnt_q     <= '0;
            if (sel_we) begin
              waddr_q   <= sel_addr;
              wdata_q   <= sel_wdata;
              mem_wen_q <= 1'b1;
              state_q   <= WR;
            end else begin
              raddr_q   <= sel_addr;
              mem_ren_q <= 1'b1;
              state_q   <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          // Data arriving on the last allowed cycle still beats the timeout.
          if (mem_rvalid_i) begin
            rsp_valid_q[id_q] <= 1'b1;
            rsp_rdata_q       <= mem_rdata_i;
            rsp_err_q         <= 1'b0;
            mem_ren_q         <= 1'b0;
            state_q           <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            rsp_valid_q[id_q] <= 1'b1;
            rsp_rdata_q       <= '0;
            rsp_err_q         <= 1'b1;
            mem_ren_q         <= 1'b0;
            state_q           <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WR: begin
          mem_wen_q         <= 1'b0;
          rsp_valid_q[id_q] <= 1'b1;
          rsp_rdata_q       <= '0;
          rsp_err_q         <= 1'b0;
          state_q           <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign mem_ren_o   = mem_ren_q;
  assign mem_raddr_o = raddr_q;
  assign mem_wen_o   = mem_wen_q;
  assign mem_waddr_o = waddr_q;
  assign mem_wdata_o = wdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lsu_mem_arbiter: randomized scoreboard bench for lsu_mem_arbiter.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_lsu_mem_arbiter;
  localparam int N  = 3;
  localparam int TO = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       rq_valid, rq_we;
  logic [N*64-1:0]    rq_addr, rq_wdata;
  logic [N-1:0]       rq_ready, rsp_valid;
  logic [63:0]        rsp_rdata;
  logic               rsp_err, busy;
  logic               mem_ren, mem_wen, mem_rvalid;
  logic [63:0]        mem_raddr, mem_rdata, mem_waddr, mem_wdata;

  always #5 clk = ~clk;

  lsu_mem_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rq_valid_i(rq_valid), .rq_we_i(rq_we), .rq_addr_i(rq_addr), .rq_wdata_i(rq_wdata),
    .rq_ready_o(rq_ready), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .busy_o(busy),
    .mem_ren_o(mem_ren), .mem_raddr_o(mem_raddr), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .mem_wen_o(mem_wen), .mem_waddr_o(mem_waddr),
    .mem_wdata_o(mem_wdata)
  );

  typedef struct {
    int          id;
    logic        err;
    logic [63:0] data;
    int          when;
  } rsp_t;

  rsp_t        sb[$];
  int          vectors = 0;
  int          errors  = 0;
  int          cyc     = 0;
  bit          run     = 0;
  bit          stim_on = 0;
  int          rr_last, free_at, rd_start, rd_l, wr_cyc;
  bit          rd_on, wr_on;
  bit [N-1:0]  granted = '0;
  logic [63:0] exp_addr, exp_wdata;
  logic [63:0] ref_mem [logic [63:0]];
  logic [63:0] phy_mem [logic [63:0]];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] init_val(input logic [63:0] a);
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0000_0000_0000_A5A5;
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory behaviour: storage follows observed writes; read latency is chosen at grant.
  always @(negedge clk) if (mem_wen === 1'b1) phy_mem[mem_waddr] = mem_wdata;

  always @(posedge clk) begin
    #1;
    if (run) begin
      mem_rvalid = 1'b0;
      mem_rdata  = {$urandom, $urandom};
      if (rd_on && rd_l < TO && cyc == rd_start + rd_l) begin
        mem_rvalid = 1'b1;
        mem_rdata  = phy_mem.exists(mem_raddr) ? phy_mem[mem_raddr] : init_val(mem_raddr);
      end else if (rd_on && rd_l >= TO && cyc == rd_start + TO) begin
        mem_rvalid = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (granted[i]) begin
          rq_valid[i] = 1'b0;
          granted[i]  = 1'b0;
        end
        if (!rq_valid[i] && stim_on && $urandom_range(0, 99) < 40) begin
          rq_valid[i]          = 1'b1;
          rq_we[i]             = 1'($urandom_range(0, 1));
          rq_addr[64*i +: 64]  = 64'($urandom_range(0, 15)) << 3;
          rq_wdata[64*i +: 64] = {$urandom, $urandom};
        end else if (rq_valid[i] && $urandom_range(0, 99) < 3) begin
          rq_valid[i] = 1'b0;
        end
      end
    end
  end

  // Reference: which requester should win now, and what it should get back.
  always @(negedge clk) begin
    if (run) begin
      int          win;
      int          lat;
      int          rd_end;
      logic [N-1:0] er;
      logic [63:0] a;
      win = -1;
      if (cyc >= free_at)
        for (int d = 1; d <= N; d++)
          if (win < 0 && rq_valid[(rr_last + d) % N]) win = (rr_last + d) % N;
      er = '0;
      if (win >= 0) er[win] = 1'b1;
      check64("rq_ready", 64'(rq_ready), 64'(er));
      check64("busy", 64'(busy), 64'(cyc < free_at));
      rd_end = rd_start + ((rd_l < TO) ? rd_l : TO - 1);
      check64("mem_ren", 64'(mem_ren), 64'(rd_on && cyc >= rd_start && cyc <= rd_end));
      if (rd_on && cyc >= rd_start && cyc <= rd_end) check64("mem_raddr", mem_raddr, exp_addr);
      check64("mem_wen", 64'(mem_wen), 64'(wr_on && cyc == wr_cyc));
      if (wr_on && cyc == wr_cyc) begin
        check64("mem_waddr", mem_waddr, exp_addr);
        check64("mem_wdata", mem_wdata, exp_wdata);
      end
      if (win >= 0) begin
        a          = rq_addr[64*win +: 64];
        exp_addr   = a;
        exp_wdata  = rq_wdata[64*win +: 64];
        rr_last    = win;
        granted[win] = 1'b1;
        if (rq_we[win]) begin
          ref_mem[a] = exp_wdata;
          sb.push_back('{win, 1'b0, 64'd0, cyc + 2});
          wr_on   = 1'b1;
          wr_cyc  = cyc + 1;
          rd_on   = 1'b0;
          free_at = cyc + 2;
        end else begin
          lat = $urandom_range(0, 99);
          if (lat < 35)      lat = 0;
          else if (lat < 60) lat = $urandom_range(1, TO - 2);
          else if (lat < 80) lat = TO - 1;
          else               lat = TO + 5;
          if (lat < TO) begin
            sb.push_back('{win, 1'b0, ref_mem.exists(a) ? ref_mem[a] : init_val(a), cyc + 2 + lat});
            free_at = cyc + 2 + lat;
          end else begin
            sb.push_back('{win, 1'b1, 64'd0, cyc + 1 + TO});
            free_at = cyc + 1 + TO;
          end
          rd_on    = 1'b1;
          rd_start = cyc + 1;
          rd_l     = lat;
          wr_on    = 1'b0;
        end
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (run) begin
      if (rsp_valid !== '0) begin
        if (sb.size() == 0) begin
          check64("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          rsp_t e;
          logic [N-1:0] ev;
          e  = sb.pop_front();
          ev = '0;
          ev[e.id] = 1'b1;
          check64("rsp_valid", 64'(rsp_valid), 64'(ev));
          check64("rsp_err", 64'(rsp_err), 64'(e.err));
          check64("rsp_rdata", rsp_rdata, e.data);
          check64("rsp_cycle", 64'(cyc), 64'(e.when));
        end
      end else if (sb.size() != 0 && sb[0].when < cyc) begin
        rsp_t e;
        e = sb.pop_front();
        check64("missing_rsp", 64'(cyc), 64'(e.when));
      end
    end
  end

  initial begin
    rst_n = 1'b0; rq_valid = '0; rq_we = '0; rq_addr = '0; rq_wdata = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check64("rst_mem_ren", 64'(mem_ren), 64'd0);
    check64("rst_mem_wen", 64'(mem_wen), 64'd0);
    check64("rst_raddr", mem_raddr, 64'd0);
    check64("rst_waddr", mem_waddr, 64'd0);
    check64("rst_wdata", mem_wdata, 64'd0);
    check64("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check64("rst_rsp_rdata", rsp_rdata, 64'd0);
    check64("rst_rsp_err", 64'(rsp_err), 64'd0);
    check64("rst_busy", 64'(busy), 64'd0);
    check64("rst_rq_ready", 64'(rq_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rq_valid = 3'b010;
    rq_addr[64 +: 64] = 64'h100;
    @(negedge clk);
    check64("dir_ready1", 64'(rq_ready), 64'(3'b010));
    @(posedge clk); #1;
    rq_valid = '0;
    @(negedge clk);
    check64("dir_ren_high", 64'(mem_ren), 64'd1);
    check64("dir_raddr", mem_raddr, 64'h100);
    #2 rst_n = 1'b0;
    #1;
    check64("dir_ren_abort", 64'(mem_ren), 64'd0);
    check64("dir_busy_abort", 64'(busy), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check64("dir_no_rsp", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rq_valid = 3'b110;
    @(negedge clk);
    check64("dir_rr_reset", 64'(rq_ready), 64'(3'b010));
    #1 rq_valid = '0;

    @(posedge clk); #2;
    rr_last = N - 1; free_at = 0; rd_on = 0; wr_on = 0; rd_start = 0; rd_l = 0; wr_cyc = 0;
    run = 1'b1; stim_on = 1'b1;
    repeat (2000) @(posedge clk);
    #2 stim_on = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (rq_valid == '0 && sb.size() == 0 && cyc > free_at + 1) break;
    end
    @(negedge clk);
    check64("drain_pending", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
